tile_stream_reader: RTL and testbench
=====================================

TILE_STREAM_READER -- requirements
Module: tile_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, BRAM word-address width.
REQ-002 SHALL have parameter WORD_BITS, default 256, BRAM word width; one word holds one tile row.
REQ-003 SHALL have parameter PIX_BITS, default 8, pixel width.
REQ-004 SHALL have parameter MAX_W, default 24, maximum tile width in pixels; MAX_W*PIX_BITS <= WORD_BITS.
REQ-005 SHALL have parameter MAX_H, default 24, maximum tile height in rows.
REQ-006 SHALL have parameter BRAM_LAT, default 2, BRAM read latency in cycles, range 1..4.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, single-cycle request to stream one tile.
REQ-010 SHALL have port cfg_base, input, ADDR_W, BRAM address of tile row 0.
REQ-011 SHALL have port cfg_cols, input, $clog2(MAX_W+1), tile width in pixels, 0..MAX_W.
REQ-012 SHALL have port cfg_rows, input, $clog2(MAX_H+1), tile height in rows, 0..MAX_H.
REQ-013 SHALL have port busy, output, 1, high from the cycle after start acceptance until done.
REQ-014 SHALL have port done, output, 1, single-cycle pulse at tile completion.
REQ-015 SHALL have port bram_en, output, 1, read strobe.
REQ-016 SHALL have port bram_addr, output, ADDR_W, read address, meaningful only when bram_en=1.
REQ-017 SHALL have port bram_rdata, input, WORD_BITS, read data.
REQ-018 SHALL have ports pix_data (PIX_BITS), pix_valid (1), pix_row_last (1), pix_tile_last (1) as outputs and pix_ready (1) as input, forming a valid/ready pixel stream.

Function
REQ-019 SHALL use FSM states IDLE, RUN, FIN: IDLE->RUN on start; RUN->FIN on handshake of the pixel with pix_tile_last=1; FIN->IDLE unconditionally; done=1 only in FIN.
REQ-020 SHALL accept start only in IDLE, latching cfg_base/cfg_cols/cfg_rows; start in RUN or FIN is ignored and the latched config is unchanged.
REQ-021 SHALL, when the latched cfg_cols=0 or cfg_rows=0, go IDLE->FIN with no bram_en and no pix_valid.
REQ-022 SHALL read row r at bram_addr = cfg_base + r modulo 2^ADDR_W, rows in ascending order 0..cfg_rows-1, each exactly once.
REQ-023 SHALL capture bram_rdata on the BRAM_LAT-th rising edge after the edge that samples bram_en=1, tracked by a BRAM_LAT-deep in-flight shift register.
REQ-024 SHALL hold two row buffers (ping-pong); bram_en is asserted only when (filled buffers + in-flight reads) < 2 and rows remain to be issued.
REQ-025 SHALL present pixel x of the current row as word bits [x*PIX_BITS +: PIX_BITS], x = 0..cfg_cols-1, row-major order; bits above cfg_cols*PIX_BITS are ignored.
REQ-026 SHALL assert pix_valid whenever the current buffer is filled; a pixel advances only on pix_valid && pix_ready.
REQ-027 SHALL hold pix_data, pix_row_last and pix_tile_last stable while pix_valid=1 and pix_ready=0.
REQ-028 SHALL set pix_row_last=1 when x=cfg_cols-1, and pix_tile_last=1 when additionally row=cfg_rows-1.
REQ-029 SHALL, on handshake of a row-last pixel, free that buffer and switch to the other buffer in the same edge; if the other is filled, pix_valid stays high with no bubble.
REQ-030 SHALL, with pix_ready held high and cfg_cols >= BRAM_LAT+2, stream one pixel per cycle across row boundaries.
REQ-031 SHALL, with start high in cycle 0, assert bram_en in cycle 1 and the first pix_valid in cycle BRAM_LAT+2.
REQ-032 SHALL, when a read capture and a buffer free occur on the same edge, apply both, with occupancy unchanged.
REQ-033 SHALL deassert busy and assert done in the cycle after the tile-last handshake; start in that FIN cycle is ignored.

Reset
REQ-034 SHALL, with rst=1 at a rising edge, enter IDLE, clear buffers, in-flight tracker and counters; busy, done, bram_en, pix_valid, pix_row_last, pix_tile_last = 0; bram_addr, pix_data = 0.
REQ-035 SHALL discard BRAM data from reads issued before a mid-tile reset; no pix_valid until the next accepted start.

Verification
REQ-036 Default params, base=0x010, cols=24, rows=3, ready=1, start cycle 0 -> bram_en cycle 1 at 0x010; pix_valid cycle 4; 72 consecutive pixels; done cycle 76.
REQ-037 cols=4, rows=2, ready toggling 1/0 -> 8 pixels in order, data stable while stalled, row_last on pixels 3 and 7, tile_last on pixel 7 only.
REQ-038 base=0xFFF, rows=2 -> read addresses 0xFFF then 0x000.
REQ-039 cols=0 or rows=0 -> done one cycle after start, no bram_en, no pix_valid.
REQ-040 ready=0 for 20 cycles after start, rows=4 -> exactly 2 reads issued then bram_en=0 until the first row-last handshake.
REQ-041 rst asserted mid-row with reads in flight -> all outputs 0 next cycle; late bram_rdata ignored; a new start streams correctly.

Source files
------------

// File: rtl/tile_stream_reader.sv
// tile_stream_reader: fetches a tile one BRAM word (row) at a time into ping-pong
// row buffers and emits it as a row-major valid/ready pixel stream.
module tile_stream_reader #(
  parameter int ADDR_W    = 12,
  parameter int WORD_BITS = 256,
  parameter int PIX_BITS  = 8,
  parameter int MAX_W     = 24,
  parameter int MAX_H     = 24,
  parameter int BRAM_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            cfg_base,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_cols,
  input  logic [$clog2(MAX_H+1)-1:0]   cfg_rows,
  output logic                         busy,
  output logic                         done,
  output logic                         bram_en,
  output logic [ADDR_W-1:0]            bram_addr,
  input  logic [WORD_BITS-1:0]         bram_rdata,
  output logic [PIX_BITS-1:0]          pix_data,
  output logic                         pix_valid,
  output logic                         pix_row_last,
  output logic                         pix_tile_last,
  input  logic                         pix_ready
);
  localparam int CW = $clog2(MAX_W + 1);
  localparam int RW = $clog2(MAX_H + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] cols, x;
  logic [RW-1:0] rows, iss, row;
  logic [WORD_BITS-1:0] rbuf [2];
  logic [1:0] fb, set_m, clr_m;
  logic wp, rp, cap, hs, rel;
  logic [BRAM_LAT-1:0] fl;
  logic [2:0] infl, occ;
  // fl[i]: a read sampled i+1 edges ago; the top bit is captured on the coming edge
  always_comb begin
    infl = 3'($countones(fl));
    occ = 3'(fb[0]) + 3'(fb[1]) + infl;
    bram_en = state == RUN && iss < rows && occ < 3'd2;
    bram_addr = base + ADDR_W'(iss);
    cap = fl[BRAM_LAT-1];
    pix_valid = state == RUN && fb[rp];
    pix_row_last = pix_valid && x == cols - 1'b1;
    pix_tile_last = pix_row_last && row == rows - 1'b1;
    pix_data = rbuf[rp][x*PIX_BITS +: PIX_BITS];
    hs = pix_valid && pix_ready;
    rel = hs && pix_row_last;
    set_m = cap ? 2'b01 << wp : 2'b00;
    clr_m = rel ? 2'b01 << rp : 2'b00;
    busy = state == RUN;
    done = state == FIN;
    state_n = state == IDLE ? (start ? (cfg_cols == '0 || cfg_rows == '0 ? FIN : RUN) : IDLE)
            : state == RUN ? (hs && pix_tile_last ? FIN : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base <= '0;
      cols <= '0;
      rows <= '0;
      x <= '0;
      row <= '0;
      iss <= '0;
      fb <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      fl <= '0;
      rbuf[0] <= '0;
      rbuf[1] <= '0;
    end else begin
      state <= state_n;
      fl <= (fl << 1) | BRAM_LAT'(bram_en);
      fb <= (fb | set_m) & ~clr_m;
      if (state == IDLE && start) begin
        base <= cfg_base;
        cols <= cfg_cols;
        rows <= cfg_rows;
        x <= '0;
        row <= '0;
        iss <= '0;
        wp <= 1'b0;
        rp <= 1'b0;
      end
      if (bram_en) iss <= iss + 1'b1;
      if (cap) begin
        rbuf[wp] <= bram_rdata;
        wp <= ~wp;
      end
      if (hs) x <= pix_row_last ? '0 : x + 1'b1;
      if (rel) begin
        row <= row + 1'b1;
        rp <= ~rp;
      end
    end
  end
endmodule

// File: tb/tb_tile_stream_reader.sv
// tb_tile_stream_reader: scoreboard bench; expected pixels and read addresses are
// queued at start and checked as the DUT reads BRAM and hands off pixels.
module tb_tile_stream_reader;
  localparam int AW = 12, WB = 256, PB = 8, MW = 24, MH = 24, LAT = 2;
  localparam int CW = $clog2(MW + 1), RW = $clog2(MH + 1);
  typedef struct packed {
    logic [PB-1:0] d;
    logic rl;
    logic tl;
  } pix_t;
  logic clk = 1'b0;
  logic rst, start, pix_ready;
  logic [AW-1:0] cfg_base;
  logic [CW-1:0] cfg_cols;
  logic [RW-1:0] cfg_rows;
  logic busy, done, bram_en, pix_valid, pix_row_last, pix_tile_last;
  logic [AW-1:0] bram_addr;
  logic [WB-1:0] bram_rdata;
  logic [PB-1:0] pix_data;
  logic [WB-1:0] pipe [LAT];
  pix_t exp_q[$];
  logic [AW-1:0] addr_q[$];
  pix_t got;
  int errors = 0, checks = 0, n_pix = 0, n_rd = 0;

  always #5 clk = ~clk;

  tile_stream_reader #(.ADDR_W(AW), .WORD_BITS(WB), .PIX_BITS(PB), .MAX_W(MW), .MAX_H(MH), .BRAM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_row_last(pix_row_last), .pix_tile_last(pix_tile_last),
    .pix_ready(pix_ready)
  );

  function automatic logic [WB-1:0] word_of(input logic [AW-1:0] a);
    logic [WB-1:0] w;
    for (int i = 0; i < WB / 8; i++) w[i*8 +: 8] = 8'(a * 7 + i * 29 + (a >> 4));
    return w;
  endfunction

  // BRAM with LAT register stages; data always flows so stale words are present after reset
  always @(posedge clk) begin
    pipe[0] <= word_of(bram_addr);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rdata = pipe[LAT-1];

  always @(negedge clk) begin
    if (!rst && bram_en) begin
      checks++;
      n_rd++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL rd_addr: got read at %h, want no read", bram_addr);
      end else begin
        if (bram_addr !== addr_q[0]) begin
          errors++;
          $display("FAIL rd_addr: got %h want %h", bram_addr, addr_q[0]);
        end
        void'(addr_q.pop_front());
      end
    end
    if (!rst && pix_valid) begin
      checks++;
      got = {pix_data, pix_row_last, pix_tile_last};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel: got valid pixel %h, want no pixel", pix_data);
      end else begin
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL pixel: got d=%h rl=%b tl=%b want d=%h rl=%b tl=%b",
                   got.d, got.rl, got.tl, exp_q[0].d, exp_q[0].rl, exp_q[0].tl);
        end
        if (pix_ready) begin
          void'(exp_q.pop_front());
          n_pix++;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [AW-1:0] b, input int c, input int r);
    logic [WB-1:0] w;
    pix_t p;
    n_pix = 0;
    n_rd = 0;
    cfg_base = b;
    cfg_cols = CW'(c);
    cfg_rows = RW'(r);
    start = 1'b1;
    if (c > 0 && r > 0)
      for (int y = 0; y < r; y++) begin
        addr_q.push_back(b + AW'(y));
        w = word_of(b + AW'(y));
        for (int xx = 0; xx < c; xx++) begin
          p.d = w[xx*PB +: PB];
          p.rl = xx == c - 1;
          p.tl = xx == c - 1 && y == r - 1;
          exp_q.push_back(p);
        end
      end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    cfg_base = '0;
    cfg_cols = '0;
    cfg_rows = '0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({busy, done, bram_en, pix_valid, pix_row_last, pix_tile_last, bram_addr, pix_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b en=%b valid=%b rl=%b tl=%b addr=%h data=%h, want all 0",
               busy, done, bram_en, pix_valid, pix_row_last, pix_tile_last, bram_addr, pix_data);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int fe = -1, fv = -1, dk = -1, bad = 0;
    step();
    pix_ready = 1'b1;
    start_tile(12'h010, 24, 3);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bram_en && fe < 0) fe = k;
      if (pix_valid && fv < 0) fv = k;
      if (done && dk < 0) dk = k;
      if (k >= 77 && (busy || bram_en || pix_valid || done)) bad++;
      step();
      start = 1'b0;
      if (k + 1 == 10 || k + 1 == 76) begin
        cfg_base = 12'h300;
        cfg_cols = CW'(5);
        cfg_rows = RW'(1);
        start = 1'b1;
      end
    end
    checks += 7;
    if (fe != 1) begin errors++; $display("FAIL basic_first_en: got cycle %0d want 1", fe); end
    if (fv != 4) begin errors++; $display("FAIL basic_first_valid: got cycle %0d want 4", fv); end
    if (dk != 76) begin errors++; $display("FAIL basic_done: got cycle %0d want 76", dk); end
    if (n_pix != 72) begin errors++; $display("FAIL basic_pixels: got %0d want 72", n_pix); end
    if (n_rd != 3) begin errors++; $display("FAIL basic_reads: got %0d want 3", n_rd); end
    if (bad != 0) begin errors++; $display("FAIL basic_fin_start: got %0d active cycles after done, want 0", bad); end
    if (exp_q.size() + addr_q.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: got %0d items left want 0", exp_q.size() + addr_q.size());
    end
  endtask

  task automatic test_stall;
    bit seen = 0;
    step();
    pix_ready = 1'b0;
    start_tile(12'h040, 4, 2);
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      step();
      start = 1'b0;
      pix_ready = (k + 1) % 2 == 1;
    end
    checks += 3;
    if (!seen) begin errors++; $display("FAIL stall_done: got no done within 100 cycles, want done"); end
    if (n_pix != 8) begin errors++; $display("FAIL stall_pixels: got %0d want 8", n_pix); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    bit seen = 0;
    step();
    pix_ready = 1'b1;
    start_tile(12'hFFF, 3, 2);
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      step();
      start = 1'b0;
    end
    checks += 3;
    if (!seen) begin errors++; $display("FAIL wrap_done: got no done within 60 cycles, want done"); end
    if (n_rd != 2) begin errors++; $display("FAIL wrap_reads: got %0d want 2", n_rd); end
    if (n_pix != 6) begin errors++; $display("FAIL wrap_pixels: got %0d want 6", n_pix); end
  endtask

  task automatic test_empty;
    for (int t = 0; t < 2; t++) begin
      int dk = -1;
      step();
      pix_ready = 1'b1;
      start_tile(12'h020, t == 0 ? 0 : 5, t == 0 ? 3 : 0);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done && dk < 0) dk = k;
        step();
        start = 1'b0;
      end
      checks += 2;
      if (dk != 1) begin errors++; $display("FAIL empty%0d_done: got cycle %0d want 1", t, dk); end
      if (n_rd + n_pix != 0) begin
        errors++;
        $display("FAIL empty%0d_activity: got %0d reads %0d pixels want 0", t, n_rd, n_pix);
      end
    end
  endtask

  task automatic test_backpressure;
    int rd19 = -1, en_k = -1;
    bit seen = 0;
    step();
    pix_ready = 1'b0;
    start_tile(12'h080, 6, 4);
    for (int k = 0; k < 150 && !seen; k++) begin
      @(negedge clk);
      if (k == 19) rd19 = n_rd;
      if (k >= 3 && bram_en && en_k < 0) en_k = k;
      if (done) seen = 1;
      step();
      start = 1'b0;
      pix_ready = k + 1 >= 20;
    end
    checks += 5;
    if (rd19 != 2) begin errors++; $display("FAIL bp_reads_stalled: got %0d want 2", rd19); end
    if (en_k != 26) begin errors++; $display("FAIL bp_third_read: got cycle %0d want 26", en_k); end
    if (!seen) begin errors++; $display("FAIL bp_done: got no done within 150 cycles, want done"); end
    if (n_rd != 4) begin errors++; $display("FAIL bp_reads: got %0d want 4", n_rd); end
    if (n_pix != 24) begin errors++; $display("FAIL bp_pixels: got %0d want 24", n_pix); end
  endtask

  task automatic test_mid_reset;
    int bad = 0;
    bit seen = 0;
    step();
    pix_ready = 1'b1;
    start_tile(12'h100, 8, 4);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, bram_en, pix_valid, pix_row_last, pix_tile_last, bram_addr, pix_data} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b done=%b en=%b valid=%b addr=%h data=%h, want all 0",
               busy, done, bram_en, pix_valid, bram_addr, pix_data);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      @(negedge clk);
      if (pix_valid || bram_en || busy || done) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); end
    step();
    start_tile(12'h200, 5, 3);
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      step();
      start = 1'b0;
    end
    checks += 4;
    if (!seen) begin errors++; $display("FAIL midrst_done: got no done within 80 cycles, want done"); end
    if (n_pix != 15) begin errors++; $display("FAIL midrst_pixels: got %0d want 15", n_pix); end
    if (n_rd != 3) begin errors++; $display("FAIL midrst_reads: got %0d want 3", n_rd); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    cfg_base = '0;
    cfg_cols = '0;
    cfg_rows = '0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_empty();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
